// File: rtl/cpu_pkg.sv
// Constants and state encoding shared between the control unit and the step sequencer.
package cpu_pkg;
    localparam int STEP_W      = 4;
    localparam int FETCH_STEPS = 5;
    localparam int MAX_STEP    = 15;
    localparam int ICNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        PAUSE  = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } cpu_state_t;
endpackage

// File: rtl/step_counter.sv
// Saturating micro-step counter; clear beats increment, increment only while enabled.
module step_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         at_max
);
    assign at_max = (q == W'(MAX));

    always_ff @(posedge clk) begin
        if (!reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && en && !at_max)
            q <= q + W'(1);
    end
endmodule

// File: rtl/step_sequencer.sv
// Micro-step counter plus run/pause/halt control, front-panel stepping, fault watchdog and retire counter.
module step_sequencer
    import cpu_pkg::*;
#(
    parameter int STEP_W      = cpu_pkg::STEP_W,
    parameter int FETCH_STEPS = cpu_pkg::FETCH_STEPS,
    parameter int MAX_STEP    = cpu_pkg::MAX_STEP,
    parameter int ICNT_W      = cpu_pkg::ICNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              single_en,
    input  logic              step_req,
    input  logic              SC_inc,
    input  logic              SC_reset,
    input  logic              HALT,
    output logic [STEP_W-1:0] step,
    output logic              cpu_run,
    output logic              halted,
    output logic              fault,
    output logic              fetch_phase,
    output logic [ICNT_W-1:0] instr_count
);
    cpu_state_t state, state_nx;
    logic       stop_pend;
    logic       at_max;
    logic       retire;
    logic       in_run;

    assign in_run      = (state == RUN);
    assign fetch_phase = (step < STEP_W'(FETCH_STEPS));
    assign retire      = SC_reset && !fetch_phase && in_run;

    step_counter #(.W(STEP_W), .MAX(MAX_STEP)) u_step (
        .clk    (clk),
        .reset  (reset),
        .clr    (SC_reset),
        .inc    (SC_inc),
        .en     (in_run),
        .q      (step),
        .at_max (at_max)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start && !stop) state_nx = RUN;
            RUN: begin
                // Overflow past the last legal step is a runaway instruction.
                if (SC_inc && !SC_reset && at_max)              state_nx = FAULT;
                else if (HALT)                                  state_nx = HALTED;
                else if (retire && (stop_pend || stop || single_en)) state_nx = PAUSE;
            end
            PAUSE:   if (start || (step_req && single_en)) state_nx = RUN;
            HALTED:  state_nx = HALTED;
            FAULT:   state_nx = FAULT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            stop_pend   <= 1'b0;
            instr_count <= '0;
            cpu_run     <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state   <= state_nx;
            cpu_run <= (state_nx == RUN);
            halted  <= (state_nx == HALTED);
            fault   <= (state_nx == FAULT);
            if (state_nx == PAUSE && state != PAUSE)
                stop_pend <= 1'b0;
            else if (in_run && stop)
                stop_pend <= 1'b1;
            if (retire)
                instr_count <= instr_count + ICNT_W'(1);
        end
    end
endmodule
